// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes and select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StInit   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_output_decode.sv
// Moore decode of the control state (plus mem_ready in FETCH) into the datapath control vector.
// ADDI_EN enables the ADDIEX/ADDIWB outputs; otherwise those codes decode to all-zero.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]        state_i,
    input  logic              mem_ready_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state_i)
            StFetch: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.ir_write  = mem_ready_i;
                c.pc_write  = mem_ready_i;
            end
            StDecode: c.alu_src_b = SRCB_IMM_SL2;
            StMemAdr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            StMemRd: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            StExec: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            StAluWb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            StBranch: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            StJump: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
`ifdef ADDI_EN
            StAddiEx: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            StAddiWb: c.reg_write = 1'b1;
`endif
            default: c = '0;
        endcase
    end

    assign ctrl_o = c;

endmodule

// File: rtl/multicycle_main_control.sv
// Main-control FSM for the multicycle MIPS datapath with memory-ready stalls and illegal-op pulse.
// Optional macro ADDI_EN adds the addi path (ADDIEX -> ADDIWB); undefined, addi is illegal.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 6,
    parameter int unsigned ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            IRWrite,
    output logic [1:0]      PCSource,
    output logic [1:0]      ALUOp,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic            RegWrite,
    output logic            RegDst,
    output logic            illegal_op,
    output logic [ST_W-1:0] state_dbg
);

    state_e            state_q, state_d;
    logic              illegal;
    logic [CTRL_W-1:0] ctrl_vec;
    ctrl_t             ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StInit;
        illegal = 1'b0;
        case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = StAddiEx;
`endif
                    default: begin
                        state_d = StFetch;
                        illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (op == OP_SW) ? StMemWr : StMemRd;
            StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
`ifdef ADDI_EN
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
`endif
            // Unencoded codes recover through INIT.
            default:  state_d = StInit;
        endcase
    end

    mc_output_decode u_output_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_vec)
    );

    assign ctrl        = ctrl_t'(ctrl_vec);
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign illegal_op  = illegal;
    assign state_dbg   = state_q;

endmodule
